fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Next-PC controller for the fetch stage. It decides every cycle which address the PC register loads: boot vector, sequential PC+4, a branch/jump redirect, a trap vector, or a hold of the current PC. It also parks redirects that arrive while fetch cannot advance and releases them later. It sits between the hazard unit, the execute stage, instruction memory, and the PC register's nextPC input.

## Interface
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset
- TRAP_VECTOR, 32'hBFC00180, address loaded on a trap
- ADDR_WIDTH, 32, PC width
- CNT_WIDTH, 16, redirect-counter width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- PCF  in  ADDR_WIDTH  current PC from the PC register
- PCPlus4F  in  ADDR_WIDTH  PCF + 4 from the PC register
- stallF  in  1  hazard-unit fetch stall
- imemReady  in  1  instruction memory accepts the fetch this cycle
- redirValid  in  1  execute-stage taken branch/jump
- redirTarget  in  ADDR_WIDTH  redirect target
- trapValid  in  1  trap request; wins over redirValid
- nextPC  out  ADDR_WIDTH  value the PC register loads at the next edge
- fetchValid  out  1  fetch request to instruction memory
- flushD  out  1  kill the instruction in the decode register
- pendingRedir  out  1  a parked redirect is held
- redirCount  out  CNT_WIDTH  saturating count of accepted redirects and traps

## Operation
- States: BOOT, RUN, HOLD, PEND. Registers: state, pendTarget, pending flag, redirCount.
- adv = !stallF && imemReady && state != BOOT.
- evt = trapValid || redirValid. evtTarget = TRAP_VECTOR if trapValid, else {redirTarget[ADDR_WIDTH-1:2], 2'b00}. The low two target bits are always forced to zero.
- nextPC priority, evaluated combinationally:
  1. BOOT: RESET_VECTOR.
  2. evt && adv: evtTarget.
  3. PEND && adv: pendTarget.
  4. adv: PCPlus4F.
  5. Otherwise: PCF (hold).
- evt && !adv: pendTarget <= evtTarget. A newer event overwrites an older parked one. Next state is PEND.
- Transitions:
  - BOOT -> RUN unconditionally.
  - RUN/HOLD: evt && !adv -> PEND; !adv -> HOLD; otherwise -> RUN.
  - PEND: adv -> RUN (target released, pending cleared); otherwise stays PEND.
- flushD = evt. It is asserted only in the arrival cycle, never on release.
- fetchValid = (state != BOOT) && !stallF.
- pendingRedir = (state == PEND).
- redirCount increments once per cycle in which evt=1 and state != BOOT. It saturates at all-ones and never wraps.
- Events in BOOT are ignored: no capture, no count, and flushD stays 0.

## Timing
- Reset: state=BOOT, pendTarget=0, redirCount=0. During reset nextPC=RESET_VECTOR, fetchValid=0, flushD=0, pendingRedir=0.
- Reset asserted mid-operation discards any parked redirect immediately; it is not released afterwards.
- BOOT lasts exactly one cycle after rst deasserts.
- nextPC, flushD and fetchValid are combinational from inputs and state, with zero-cycle latency.
- Redirect at edge-cycle N with adv=1: PCF = target in cycle N+1.
- Redirect at cycle N with adv=0: PCF holds. It becomes the target one cycle after the first cycle with adv=1.
- trapValid and redirValid in the same cycle: the trap target wins and redirCount increments by 1 only.
- stallF=1 with imemReady=1 is treated as no advance.

## Test plan
- Reset release, no stall, imemReady=1:
  - cycle 0 nextPC=0xBFC00000, fetchValid=0;
  - then PCF sequence 0xBFC00000, 0xBFC00004, 0xBFC00008.
- PCF=0xBFC00010, redirValid=1, redirTarget=0xBFC00043, adv=1 -> nextPC=0xBFC00040, flushD=1, redirCount=1; next cycle flushD=0.
- Redirect to 0xBFC00100 with stallF=1 for 3 cycles:
  - nextPC=PCF throughout, pendingRedir=1 from the cycle after arrival, flushD=1 in the arrival cycle only;
  - in the first unstalled cycle nextPC=0xBFC00100 and pendingRedir drops the cycle after.
- trapValid=1 and redirValid=1 (target 0xBFC00200) together with adv=1 -> nextPC=0xBFC00180, redirCount+1.
- Park a redirect (imemReady=0), then assert rst mid-PEND -> pendingRedir=0 at once; after release the fetch starts at 0xBFC00000, not at the parked target.
- Preload redirCount near saturation via 65535+ events -> count stops at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : next-PC selection for the fetch stage (boot, PC+4,
//                   redirect, trap, hold) with parking of blocked redirects.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    CNT_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 32'hBFC00180
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCF,
  input  logic [ADDR_WIDTH-1:0] PCPlus4F,
  input  logic                  stallF,
  input  logic                  imemReady,
  input  logic                  redirValid,
  input  logic [ADDR_WIDTH-1:0] redirTarget,
  input  logic                  trapValid,
  output logic [ADDR_WIDTH-1:0] nextPC,
  output logic                  fetchValid,
  output logic                  flushD,
  output logic                  pendingRedir,
  output logic [CNT_WIDTH-1:0]  redirCount
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    PEND = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   pend_target;
  logic [ADDR_WIDTH-1:0]   evt_target;
  logic                    adv;
  logic                    evt;
  logic                    live_evt;
  logic                    park;

  always_comb begin
    adv        = !stallF && imemReady && (state != BOOT);
    evt        = trapValid || redirValid;
    live_evt   = evt && (state != BOOT);
    park       = live_evt && !adv;
    evt_target = trapValid ? TRAP_VECTOR : (redirTarget & ALIGN_MASK);
  end

  always_comb begin
    next_state = state;
    nextPC     = PCF;
    case (state)
      BOOT: begin
        next_state = RUN;
        nextPC     = RESET_VECTOR;
      end
      RUN, HOLD: begin
        if (park)      next_state = PEND;
        else if (!adv) next_state = HOLD;
        else           next_state = RUN;
        if (evt && adv) nextPC = evt_target;
        else if (adv)   nextPC = PCPlus4F;
      end
      PEND: begin
        // A fresh event on the releasing cycle supersedes the parked target.
        if (adv) next_state = RUN;
        if (evt && adv) nextPC = evt_target;
        else if (adv)   nextPC = pend_target;
      end
      default: begin
        next_state = BOOT;
        nextPC     = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pend_target <= '0;
      redirCount  <= '0;
    end else begin
      state <= next_state;
      if (park)
        pend_target <= evt_target;
      if (live_evt && (redirCount != {CNT_WIDTH{1'b1}}))
        redirCount <= redirCount + 1'b1;
    end
  end

  assign fetchValid   = (state != BOOT) && !stallF;
  assign flushD       = live_evt;
  assign pendingRedir = (state == PEND);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : directed self-checking bench for fetch_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        stallF;
  logic        imemReady;
  logic        redirValid;
  logic [31:0] redirTarget;
  logic        trapValid;
  logic [31:0] nextPC;
  logic        fetchValid;
  logic        flushD;
  logic        pendingRedir;
  logic [15:0] redirCount;

  int passed = 0;
  int total  = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PCPlus4F(PCPlus4F), .stallF(stallF),
    .imemReady(imemReady), .redirValid(redirValid), .redirTarget(redirTarget),
    .trapValid(trapValid), .nextPC(nextPC), .fetchValid(fetchValid),
    .flushD(flushD), .pendingRedir(pendingRedir), .redirCount(redirCount)
  );

  always #5 clk = ~clk;

  // PC register fed by the DUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) PCF <= 32'h0;
    else     PCF <= nextPC;
  end
  assign PCPlus4F = PCF + 32'd4;

  // Inputs change right after the falling edge; checks are made 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallF = 1'b0; imemReady = 1'b1;
    redirValid = 1'b0; trapValid = 1'b0; redirTarget = 32'h0;
    repeat (2) tick();
    settle();
    total++; if (nextPC !== 32'hBFC00000) $display("FAIL rst_nextPC got=%h exp=%h", nextPC, 32'hBFC00000); else passed++;
    total++; if (fetchValid !== 1'b0) $display("FAIL rst_fetchValid got=%b exp=0", fetchValid); else passed++;
    total++; if (flushD !== 1'b0) $display("FAIL rst_flushD got=%b exp=0", flushD); else passed++;
    total++; if (pendingRedir !== 1'b0) $display("FAIL rst_pending got=%b exp=0", pendingRedir); else passed++;
    total++; if (redirCount !== 16'h0) $display("FAIL rst_count got=%h exp=0", redirCount); else passed++;
  endtask

  task automatic test_boot_sequence();
    tick(); rst = 1'b0; settle();
    total++; if (nextPC !== 32'hBFC00000) $display("FAIL boot_nextPC got=%h exp=%h", nextPC, 32'hBFC00000); else passed++;
    total++; if (fetchValid !== 1'b0) $display("FAIL boot_fetchValid got=%b exp=0", fetchValid); else passed++;
    tick(); settle();
    total++; if (PCF !== 32'hBFC00000) $display("FAIL seq_pc0 got=%h exp=%h", PCF, 32'hBFC00000); else passed++;
    total++; if (fetchValid !== 1'b1) $display("FAIL seq_fetchValid got=%b exp=1", fetchValid); else passed++;
    tick(); settle();
    total++; if (PCF !== 32'hBFC00004) $display("FAIL seq_pc1 got=%h exp=%h", PCF, 32'hBFC00004); else passed++;
    tick(); settle();
    total++; if (PCF !== 32'hBFC00008) $display("FAIL seq_pc2 got=%h exp=%h", PCF, 32'hBFC00008); else passed++;
    tick(); tick(); settle();
    total++; if (PCF !== 32'hBFC00010) $display("FAIL seq_pc4 got=%h exp=%h", PCF, 32'hBFC00010); else passed++;
  endtask

  task automatic test_redirect();
    redirValid = 1'b1; redirTarget = 32'hBFC00043; settle();
    total++; if (nextPC !== 32'hBFC00040) $display("FAIL redir_nextPC got=%h exp=%h", nextPC, 32'hBFC00040); else passed++;
    total++; if (flushD !== 1'b1) $display("FAIL redir_flush got=%b exp=1", flushD); else passed++;
    tick(); redirValid = 1'b0; settle();
    total++; if (redirCount !== 16'd1) $display("FAIL redir_count got=%0d exp=1", redirCount); else passed++;
    total++; if (flushD !== 1'b0) $display("FAIL redir_flush_next got=%b exp=0", flushD); else passed++;
    total++; if (PCF !== 32'hBFC00040) $display("FAIL redir_pc got=%h exp=%h", PCF, 32'hBFC00040); else passed++;
  endtask

  task automatic test_stalled_redirect();
    redirValid = 1'b1; redirTarget = 32'hBFC00100; stallF = 1'b1; settle();
    total++; if (nextPC !== 32'hBFC00040) $display("FAIL stall_hold0 got=%h exp=%h", nextPC, 32'hBFC00040); else passed++;
    total++; if (flushD !== 1'b1) $display("FAIL stall_flush_arrival got=%b exp=1", flushD); else passed++;
    total++; if (pendingRedir !== 1'b0) $display("FAIL stall_pending_arrival got=%b exp=0", pendingRedir); else passed++;
    total++; if (fetchValid !== 1'b0) $display("FAIL stall_fetchValid got=%b exp=0", fetchValid); else passed++;
    for (int i = 1; i < 3; i++) begin
      tick(); redirValid = 1'b0; settle();
      total++; if (nextPC !== 32'hBFC00040) $display("FAIL stall_hold%0d got=%h exp=%h", i, nextPC, 32'hBFC00040); else passed++;
      total++; if (pendingRedir !== 1'b1) $display("FAIL stall_pending%0d got=%b exp=1", i, pendingRedir); else passed++;
      total++; if (flushD !== 1'b0) $display("FAIL stall_flush%0d got=%b exp=0", i, flushD); else passed++;
    end
    tick(); stallF = 1'b0; settle();
    total++; if (nextPC !== 32'hBFC00100) $display("FAIL stall_release got=%h exp=%h", nextPC, 32'hBFC00100); else passed++;
    total++; if (flushD !== 1'b0) $display("FAIL stall_release_flush got=%b exp=0", flushD); else passed++;
    tick(); settle();
    total++; if (pendingRedir !== 1'b0) $display("FAIL stall_pending_clear got=%b exp=0", pendingRedir); else passed++;
    total++; if (PCF !== 32'hBFC00100) $display("FAIL stall_pc got=%h exp=%h", PCF, 32'hBFC00100); else passed++;
    total++; if (redirCount !== 16'd2) $display("FAIL stall_count got=%0d exp=2", redirCount); else passed++;
  endtask

  task automatic test_trap_priority();
    trapValid = 1'b1; redirValid = 1'b1; redirTarget = 32'hBFC00200; settle();
    total++; if (nextPC !== 32'hBFC00180) $display("FAIL trap_nextPC got=%h exp=%h", nextPC, 32'hBFC00180); else passed++;
    tick(); trapValid = 1'b0; redirValid = 1'b0; settle();
    total++; if (redirCount !== 16'd3) $display("FAIL trap_count got=%0d exp=3", redirCount); else passed++;
    total++; if (PCF !== 32'hBFC00180) $display("FAIL trap_pc got=%h exp=%h", PCF, 32'hBFC00180); else passed++;
  endtask

  task automatic test_overwrite();
    imemReady = 1'b0; redirValid = 1'b1; redirTarget = 32'hBFC00400;
    tick(); redirTarget = 32'hBFC00502; settle();
    total++; if (pendingRedir !== 1'b1) $display("FAIL ovw_pending got=%b exp=1", pendingRedir); else passed++;
    tick(); redirValid = 1'b0; imemReady = 1'b1; settle();
    total++; if (nextPC !== 32'hBFC00500) $display("FAIL ovw_release got=%h exp=%h", nextPC, 32'hBFC00500); else passed++;
    total++; if (redirCount !== 16'd5) $display("FAIL ovw_count got=%0d exp=5", redirCount); else passed++;
    tick(); settle();
  endtask

  task automatic test_reset_mid_pend();
    imemReady = 1'b0; redirValid = 1'b1; redirTarget = 32'hBFC00300;
    tick(); redirValid = 1'b0; settle();
    total++; if (pendingRedir !== 1'b1) $display("FAIL rpend_parked got=%b exp=1", pendingRedir); else passed++;
    rst = 1'b1; settle();
    total++; if (pendingRedir !== 1'b0) $display("FAIL rpend_drop got=%b exp=0", pendingRedir); else passed++;
    total++; if (nextPC !== 32'hBFC00000) $display("FAIL rpend_rst_nextPC got=%h exp=%h", nextPC, 32'hBFC00000); else passed++;
    imemReady = 1'b1;
    tick(); rst = 1'b0; redirValid = 1'b1; redirTarget = 32'hBFC00700; settle();
    total++; if (flushD !== 1'b0) $display("FAIL boot_evt_flush got=%b exp=0", flushD); else passed++;
    total++; if (nextPC !== 32'hBFC00000) $display("FAIL boot_evt_nextPC got=%h exp=%h", nextPC, 32'hBFC00000); else passed++;
    tick(); redirValid = 1'b0; settle();
    total++; if (PCF !== 32'hBFC00000) $display("FAIL rpend_pc got=%h exp=%h", PCF, 32'hBFC00000); else passed++;
    total++; if (nextPC !== 32'hBFC00004) $display("FAIL rpend_nextPC got=%h exp=%h", nextPC, 32'hBFC00004); else passed++;
    total++; if (redirCount !== 16'd0) $display("FAIL boot_evt_count got=%0d exp=0", redirCount); else passed++;
    total++; if (pendingRedir !== 1'b0) $display("FAIL rpend_after got=%b exp=0", pendingRedir); else passed++;
  endtask

  task automatic test_saturation();
    redirValid = 1'b1; redirTarget = 32'hBFC00600;
    repeat (65534) tick();
    settle();
    total++; if (redirCount !== 16'hFFFE) $display("FAIL sat_near got=%h exp=fffe", redirCount); else passed++;
    repeat (3) tick();
    settle();
    total++; if (redirCount !== 16'hFFFF) $display("FAIL sat_stop got=%h exp=ffff", redirCount); else passed++;
    total++; if (flushD !== 1'b1) $display("FAIL sat_flush got=%b exp=1", flushD); else passed++;
    redirValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot_sequence();
    test_redirect();
    test_stalled_redirect();
    test_trap_priority();
    test_overwrite();
    test_reset_mid_pend();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
